// File: rtl/vx_rr_slot_dispatcher_pkg.sv
// Shared helpers for the round-robin slot dispatcher: index width derivation.
package vx_rr_slot_dispatcher_pkg;

    // Index width for n slots; a single slot still needs one bit of index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_rr_slot_dispatcher_lzc.sv
// Zero-count encoder: REVERSE=1 gives the trailing-zero index (lowest set bit),
// REVERSE=0 gives the leading-zero count. valid_out flags a non-zero input.
module vx_rr_slot_dispatcher_lzc
    import vx_rr_slot_dispatcher_pkg::*;
#(
    parameter int N       = 8,
    parameter int REVERSE = 1,
    parameter int LOGN    = idx_width(N)
) (
    input  logic [N-1:0]    data_in,
    output logic [LOGN-1:0] cnt_out,
    output logic            valid_out
);

    // Later hits overwrite earlier ones, so scan order decides which end wins.
    always_comb begin
        cnt_out   = '0;
        valid_out = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (REVERSE != 0) begin
                if (data_in[N-1-i]) begin
                    cnt_out   = LOGN'(N - 1 - i);
                    valid_out = 1'b1;
                end
            end else begin
                if (data_in[i]) begin
                    cnt_out   = LOGN'(N - 1 - i);
                    valid_out = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vx_rr_slot_dispatcher.sv
// Pending-slot bitmask with round-robin (or fixed-priority) dispatch of one slot
// index per valid/ready handshake on a registered output port.
module vx_rr_slot_dispatcher
    import vx_rr_slot_dispatcher_pkg::*;
#(
    parameter int N    = 8,
    parameter int RR   = 1,
    parameter int LOGN = idx_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [N-1:0]    set_mask,
    output logic            issue_valid,
    output logic [LOGN-1:0] issue_idx,
    input  logic            issue_ready,
    output logic [N-1:0]    pending,
    output logic            empty
);

    typedef logic [LOGN-1:0] idx_t;

    logic [N-1:0] pending_q, pending_d;
    idx_t         ptr_q, ptr_d;
    logic         issue_valid_q, issue_valid_d;
    idx_t         issue_idx_q, issue_idx_d;

    logic [N-1:0] lo_mask, hi_vec, sel_onehot;
    idx_t         hi_idx, all_idx, sel;
    logic         hi_valid, any_pending, load;

    // Slots below the pointer are only served once nothing at or above it is pending.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lo_mask[i] = (i < int'(ptr_q));
        end
        hi_vec = pending_q & ~lo_mask;
    end

    vx_rr_slot_dispatcher_lzc #(.N(N), .REVERSE(1), .LOGN(LOGN)) u_lzc_hi (
        .data_in   (hi_vec),
        .cnt_out   (hi_idx),
        .valid_out (hi_valid)
    );

    vx_rr_slot_dispatcher_lzc #(.N(N), .REVERSE(1), .LOGN(LOGN)) u_lzc_all (
        .data_in   (pending_q),
        .cnt_out   (all_idx),
        .valid_out (any_pending)
    );

    // Handshake: issue_idx is offered while issue_valid is high and is held
    // unchanged until issue_valid && issue_ready; a new slot loads on that edge.
    always_comb begin
        sel  = hi_valid ? hi_idx : all_idx;
        load = any_pending && (!issue_valid_q || issue_ready) && !flush;

        for (int i = 0; i < N; i++) begin
            sel_onehot[i] = load && (sel == idx_t'(i));
        end

        pending_d     = (pending_q & ~sel_onehot) | set_mask;
        ptr_d         = ptr_q;
        issue_valid_d = issue_valid_q;
        issue_idx_d   = issue_idx_q;

        if (load) begin
            issue_valid_d = 1'b1;
            issue_idx_d   = sel;
            if (RR != 0 && N > 1) begin
                ptr_d = (sel == idx_t'(N - 1)) ? '0 : sel + idx_t'(1);
            end
        end else if (issue_ready) begin
            issue_valid_d = 1'b0;
        end

        // Flush drops everything, including sets arriving in the same cycle.
        if (flush) begin
            pending_d     = '0;
            ptr_d         = '0;
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q     <= '0;
            ptr_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
        end else begin
            pending_q     <= pending_d;
            ptr_q         <= ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_idx   = issue_idx_q;
    assign pending     = pending_q;
    assign empty       = !any_pending && !issue_valid_q;

endmodule

// File: tb/tb_vx_rr_slot_dispatcher.sv
// Randomized and directed checks of vx_rr_slot_dispatcher (N=8, RR=1) against a
// circular-scan reference model.
module tb_vx_rr_slot_dispatcher;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] set_mask = '0;
  logic       issue_ready = 1'b0;
  logic       issue_valid;
  logic [2:0] issue_idx;
  logic [7:0] pending;
  logic       empty;

  vx_rr_slot_dispatcher #(.N(N), .RR(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .set_mask    (set_mask),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .issue_ready (issue_ready),
    .pending     (pending),
    .empty       (empty)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] m_pend;
  int         m_ptr;
  int         m_idx;
  bit         m_valid;

  // scoreboard: indices the DUT handed over, and the expected ones
  logic [2:0] seen_q[$];
  logic [2:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_ptr   = 0;
    m_idx   = 0;
    m_valid = 1'b0;
  endtask

  // Next state from the behavioural rules: circular search from the pointer.
  task automatic model_step(input logic [7:0] s, input logic r, input logic f);
    bit ld;
    int sel;
    ld = (m_pend != 0) && (!m_valid || r) && !f;
    if (f) begin
      model_reset_keep_idx();
    end else begin
      if (ld) begin
        sel = -1;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (sel < 0 && m_pend[j]) sel = j;
        end
        m_pend[sel] = 1'b0;
        m_idx   = sel;
        m_valid = 1'b1;
        m_ptr   = (sel + 1) % N;
      end else if (r) begin
        m_valid = 1'b0;
      end
      m_pend = m_pend | s;
    end
  endtask

  task automatic model_reset_keep_idx();
    m_pend  = '0;
    m_ptr   = 0;
    m_valid = 1'b0;
  endtask

  task automatic check_all();
    chk("issue_valid", 32'(issue_valid), 32'(m_valid));
    chk("issue_idx", 32'(issue_idx), 32'(m_idx));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("empty", 32'(empty), 32'((m_pend == 0) && !m_valid));
  endtask

  // driver: compare settled outputs, apply next inputs, advance the model
  task automatic cycle(input logic [7:0] s, input logic r, input logic f);
    @(negedge clk);
    check_all();
    set_mask    = s;
    issue_ready = r;
    flush       = f;
    if (issue_valid && r) seen_q.push_back(issue_idx);
    model_step(s, r, f);
  endtask

  // Asynchronous reset in the middle of a clock phase; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_valid", 32'(issue_valid), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    model_reset();
    set_mask    = '0;
    issue_ready = 1'b0;
    flush       = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seen_q.delete();
  endtask

  task automatic compare_seen(input string name);
    chk({name, "_count"}, 32'(seen_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      chk(name, 32'(seen_q[i]), 32'(exp_q[i]));
    end
    seen_q.delete();
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_pending", 32'(pending), 32'h0);
    chk("init_valid", 32'(issue_valid), 32'h0);
    chk("init_idx", 32'(issue_idx), 32'h0);
    chk("init_empty", 32'(empty), 32'h1);
    reset = 1'b0;

    // Burst: three bits set at once dispatch in ascending order.
    cycle(8'b1001_0100, 1'b1, 1'b0);
    repeat (5) cycle(8'h00, 1'b1, 1'b0);
    chk("burst_empty", 32'(empty), 32'h1);
    exp_q = '{3'd2, 3'd4, 3'd7};
    compare_seen("burst_seq");

    // Fairness: two always-requesting slots alternate.
    cycle(8'h00, 1'b1, 1'b1);
    seen_q.delete();
    repeat (12) cycle(8'h21, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2) ? 3'd5 : 3'd0);
    while (seen_q.size() > 8) void'(seen_q.pop_back());
    compare_seen("fair_seq");

    // Backpressure: idx 3 held while ready is low, new sets still land in pending.
    do_reset();
    cycle(8'h08, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h40, 1'b0, 1'b0);
    chk("bp_idx_first", 32'(issue_idx), 32'd3);
    chk("bp_valid_first", 32'(issue_valid), 32'h1);
    repeat (4) cycle(8'h02, 1'b0, 1'b0);
    chk("bp_idx_held", 32'(issue_idx), 32'd3);
    cycle(8'h00, 1'b1, 1'b0);
    chk("bp_pending", 32'(pending), 32'h42);
    cycle(8'h00, 1'b1, 1'b0);
    chk("bp_next_idx", 32'(issue_idx), 32'd6);
    chk("bp_next_valid", 32'(issue_valid), 32'h1);

    // Wrap: after 6 the pointer sits at 7, so 7 goes before 1.
    do_reset();
    cycle(8'h40, 1'b1, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h82, 1'b0, 1'b0);
    repeat (3) cycle(8'h00, 1'b1, 1'b0);
    exp_q = '{3'd6, 3'd7, 3'd1};
    compare_seen("wrap_seq");

    // Re-arm the in-flight slot, then flush with a concurrent set.
    do_reset();
    cycle(8'h10, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h10, 1'b0, 1'b0);
    repeat (2) cycle(8'h00, 1'b1, 1'b0);
    exp_q = '{3'd4, 3'd4};
    compare_seen("rearm_seq");
    cycle(8'h23, 1'b1, 1'b0);
    cycle(8'h08, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b0);
    chk("flush_pending", 32'(pending), 32'h0);
    chk("flush_valid", 32'(issue_valid), 32'h0);
    chk("flush_empty", 32'(empty), 32'h1);

    // Random traffic with occasional flush and mid-traffic reset.
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] s;
      logic       r;
      logic       f;
      s = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 49) == 0);
      cycle(s, r, f);
      if (c % 700 == 699) begin
        cycle(8'hff, 1'b0, 1'b0);
        do_reset();
      end
    end
    cycle(8'h00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
